// File: rtl/grey_rgb_packer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : grey_rgb_packer
//  Brief    : Decimates the 2x2 grey stream to one pixel per quad, expands it to
//             R=G=B, buffers it in a show-ahead FIFO with frame-coherent drop.
//             Optional binarisation when GREY_PACKER_THRESH_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module grey_rgb_packer #(
    parameter int         DEPTH  = 16,
    parameter logic [9:0] THRESH = 10'd512
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [10:0]              iX_Cont,
    input  logic [10:0]              iY_Cont,
    input  logic [11:0]              iDATA,
    input  logic                     iDVAL,
    input  logic                     iREADY,
    output logic [9:0]               oRed,
    output logic [9:0]               oGreen,
    output logic [9:0]               oBlue,
    output logic [9:0]               oX_Cont,
    output logic [9:0]               oY_Cont,
    output logic                     oSOF,
    output logic                     oDVAL,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oOverflow
);

    localparam int                  c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]   c_FULL   = (c_ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        RUN      = 2'd1,
        DROP     = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_s1_valid;
    logic [9:0]             r_s1_colour;
    logic [9:0]             r_s1_x;
    logic [9:0]             r_s1_y;
    logic                   r_s1_sof;

    logic [30:0]            r_mem [DEPTH];
    logic [c_ADDR_W-1:0]    r_wptr;
    logic [c_ADDR_W-1:0]    r_rptr;
    logic [c_ADDR_W:0]      r_count;
    logic                   r_ovf;

    logic [9:0]             w_colour;
    logic                   w_qualify;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_can_push;
    logic                   w_ovf_nxt;
    logic [30:0]            w_head;
    logic                   w_unused;

    assign w_unused  = ^{THRESH, iDATA[1:0]};
    assign w_qualify = iDVAL & iX_Cont[0] & iY_Cont[0];

`ifdef GREY_PACKER_THRESH_EN
    assign w_colour = (iDATA[11:2] >= THRESH) ? 10'h3FF : 10'h000;
`else
    assign w_colour = iDATA[11:2];
`endif

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_s1_valid  <= 1'b0;
            r_s1_colour <= '0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_sof    <= 1'b0;
        end else begin
            r_s1_valid  <= w_qualify;
            r_s1_colour <= w_colour;
            r_s1_x      <= iX_Cont[10:1];
            r_s1_y      <= iY_Cont[10:1];
            r_s1_sof    <= (iX_Cont == 11'd1) && (iY_Cont == 11'd1);
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push
    assign oDVAL      = (r_count != '0);
    assign w_pop      = oDVAL & iREADY;
    assign w_can_push = (r_count != c_FULL) | w_pop;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= WAIT_SOF;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            RUN: begin
                if (r_s1_valid) begin
                    if (w_can_push) begin
                        w_push = 1'b1;
                    end else begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = DROP;
                    end
                end
            end
            WAIT_SOF, DROP: begin
                // Only a start-of-frame pixel can resynchronise the stream
                if (r_s1_valid && r_s1_sof) begin
                    if (w_can_push) begin
                        w_push      = 1'b1;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = RUN;
                    end else begin
                        w_ovf_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_s1_colour, r_s1_x, r_s1_y, r_s1_sof};
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry is masked while empty so outputs read zero after reset
    assign w_head    = oDVAL ? r_mem[r_rptr] : 31'd0;
    assign oRed      = w_head[30:21];
    assign oGreen    = w_head[30:21];
    assign oBlue     = w_head[30:21];
    assign oX_Cont   = w_head[20:11];
    assign oY_Cont   = w_head[10:1];
    assign oSOF      = w_head[0];
    assign oLevel    = r_count;
    assign oOverflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/grey_rgb_packer.md
# grey_rgb_packer

Consumer of the greyscale pixel stream (12-bit grey, X/Y counters, data-valid) produced by the camera pipeline's 2x2 grey stage. Keeps one pixel per complete 2x2 quad (odd X and odd Y), expands it to a 10-bit R=G=B triplet and buffers it in a small FIFO. Drains through a valid/ready handshake toward the SDRAM write port / display path. Frame-coherent overflow handling: once a pixel is lost, the rest of that frame is discarded.

## Interface
- DEPTH, 16: FIFO entries, power of two, 4..256
- THRESH, 10'd512: binarisation threshold, used only with GREY_PACKER_THRESH_EN
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-low
- iX_Cont  in  11  input column counter
- iY_Cont  in  11  input row counter
- iDATA  in  12  greyscale pixel
- iDVAL  in  1  input pixel valid, no backpressure
- iREADY  in  1  downstream ready
- oRed, oGreen, oBlue  out  10  output pixel, always equal
- oX_Cont, oY_Cont  out  10  output coordinates, iX_Cont[10:1] / iY_Cont[10:1]
- oSOF  out  1  current output pixel is output coordinate (0,0)
- oDVAL  out  1  output valid
- oLevel  out  $clog2(DEPTH)+1  FIFO occupancy
- oOverflow  out  1  sticky, a pixel was dropped in the current frame

## Operation
- Qualify: pixel accepted when iDVAL & iX_Cont[0] & iY_Cont[0]; all other pixels ignored.
- Convert: colour = iDATA[11:2] (truncate, no rounding). SOF flag = (iX_Cont==1 && iY_Cont==1).
- Stage register S1 holds {colour, X>>1, Y>>1, SOF, valid}; FIFO entry width 10+10+10+1 = 31 bits.
- FIFO is show-ahead: head entry drives outputs whenever oDVAL=1. Pop when oDVAL & iREADY.
- Push allowed when not full, or full with a pop in the same cycle (simultaneous push/pop at full keeps level at DEPTH). Push+pop at empty is not a bypass: entry appears next cycle.
- State machine:
  - WAIT_SOF (reset): discard everything until an S1 entry with SOF=1; push it and go RUN.
  - RUN: push every S1 entry. If S1 valid and push not allowed: drop it, set oOverflow, go DROP.
  - DROP: discard all S1 entries; on S1 SOF=1 go RUN, push it, clear oOverflow.
- SOF with FIFO full in WAIT_SOF/DROP: SOF dropped, stay in current state, oOverflow set.
- oOverflow cleared only on transition into RUN via SOF (and reset).
- Downstream may hold iREADY low indefinitely; output fields are stable while oDVAL=1 and iREADY=0.
- Reset mid-frame: FIFO flushed, state WAIT_SOF, remainder of frame discarded.

## Timing
- Reset values: oRed/oGreen/oBlue=0, oX_Cont=oY_Cont=0, oSOF=0, oDVAL=0, oLevel=0, oOverflow=0; state WAIT_SOF.
- Qualified input at edge N → S1 at N → FIFO write at N+1 → oDVAL high after N+1 (latency 2 edges, empty FIFO).
- Pop at edge M: next entry (if any) visible after M; oLevel updates on the same edge as push/pop.
- Full throughput: one output pixel per cycle with iREADY held high; input rate at most one qualified pixel per 2 cycles by construction.
- oOverflow asserts the edge after the dropped pixel leaves S1.

## Configuration
- GREY_PACKER_THRESH_EN defined: colour = (iDATA[11:2] >= THRESH) ? 10'h3FF : 10'h000, applied before S1; coordinates, SOF, handshake unchanged.
- Undefined: pass-through truncation; THRESH ignored.

## Test plan
- Reset release, frame 4x4 input starting at (0,0), iREADY=1 → 4 outputs at (0,0),(1,0),(0,1),(1,1); first with oSOF=1; iDATA=12'hABC → colour 10'h2AF.
- Stream starts mid-frame at row 3 → no output until the pixel at input (1,1) of the next frame; then oSOF=1.
- iREADY=0, DEPTH=16, feed 20 qualified pixels → oLevel=16, oOverflow=1, state DROP; raise iREADY → exactly 16 pixels out, then nothing until next SOF, which clears oOverflow.
- FIFO full, push and pop in the same cycle → oLevel stays 16, no overflow, order preserved.
- Assert iRST low with 5 entries queued → oDVAL=0, oLevel=0 immediately; recovery only at next SOF.
- With GREY_PACKER_THRESH_EN, THRESH=512: iDATA 12'h800 → 10'h3FF; iDATA 12'h7FC → 10'h000.
